// File: rtl/adma_seq_ctrl.sv
// ADMA descriptor sequencer: walks a descriptor chain in memory, launches
// data-mover transfers, handles block-gap pause/continue and error capture.
module adma_seq_ctrl (
    input  logic        clk_in_COM,
    input  logic        reset_in_COM,
    input  logic        start_REG,
    input  logic        enable_transfer_mode_REG,
    input  logic [63:0] desc_base_REG,
    input  logic        stop_block_gap_REG,
    input  logic        continue_block_gap_REG,
    input  logic        error_in_COM,
    output logic        desc_rd_req,
    output logic [63:0] desc_addr_out,
    input  logic        desc_rd_ack,
    input  logic [95:0] desc_in,
    output logic        xfer_start,
    output logic [63:0] xfer_addr,
    output logic [16:0] xfer_len,
    input  logic        block_done,
    input  logic        xfer_done,
    output logic        pause_out,
    output logic        busy,
    output logic        transfer_complete_DAT,
    output logic        int_pulse,
    output logic        dma_error
);

    localparam int unsigned ADDR_W      = 64;
    localparam int unsigned LEN_W       = 17;
    localparam int unsigned DESC_STRIDE = 12;

    localparam logic [1:0] ACT_TRAN = 2'b10;
    localparam logic [1:0] ACT_LINK = 2'b11;

    typedef enum logic [2:0] {IDLE, FDS, CADR, TFR, GAP, ERR} state_e;

    // Only the descriptor fields the sequencer acts on are kept.
    typedef struct packed {
        logic [63:0] addr;
        logic [15:0] len;
        logic [1:0]  act;
        logic        irq;
        logic        last;
        logic        valid;
    } desc_t;

    state_e              state_q;
    desc_t               desc_q;
    logic [ADDR_W-1:0]   desc_addr_q;
    logic [ADDR_W-1:0]   xfer_addr_q;
    logic [LEN_W-1:0]    xfer_len_q;
    logic                req_q, xfer_start_q, pause_q, busy_q;
    logic                complete_q, int_q, err_q;

    logic [ADDR_W-1:0]   next_addr_d;
    logic [LEN_W-1:0]    xfer_len_d;
    desc_t               desc_d;
    logic                start_ok;
    logic                unused_desc_bits;

    always_comb begin
        next_addr_d = ADDR_W'(desc_addr_q + ADDR_W'(DESC_STRIDE));
        // A zero length field encodes the maximum 64 KiB transfer.
        xfer_len_d  = (desc_q.len == 16'd0) ? LEN_W'(17'h10000) : LEN_W'({1'b0, desc_q.len});
        desc_d      = '{addr: desc_in[95:32], len: desc_in[31:16], act: desc_in[5:4],
                        irq: desc_in[2], last: desc_in[1], valid: desc_in[0]};
        start_ok    = start_REG & enable_transfer_mode_REG;
    end

    assign unused_desc_bits = ^{desc_in[15:6], desc_in[3]};

    always_ff @(posedge clk_in_COM or posedge reset_in_COM) begin
        if (reset_in_COM) begin
            state_q      <= IDLE;
            desc_q       <= '0;
            desc_addr_q  <= '0;
            xfer_addr_q  <= '0;
            xfer_len_q   <= '0;
            req_q        <= 1'b0;
            xfer_start_q <= 1'b0;
            pause_q      <= 1'b0;
            busy_q       <= 1'b0;
            complete_q   <= 1'b0;
            int_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            xfer_start_q <= 1'b0;
            complete_q   <= 1'b0;
            int_q        <= 1'b0;
            // A host error pre-empts every other event once a chain is active.
            if (error_in_COM && state_q != IDLE) begin
                state_q <= ERR;
                req_q   <= 1'b0;
                busy_q  <= 1'b0;
                pause_q <= 1'b0;
                err_q   <= 1'b1;
            end else begin
                case (state_q)
                    IDLE, ERR: begin
                        if (start_ok) begin
                            state_q     <= FDS;
                            desc_addr_q <= desc_base_REG;
                            req_q       <= 1'b1;
                            busy_q      <= 1'b1;
                            err_q       <= 1'b0;
                        end
                    end
                    FDS: begin
                        if (desc_rd_ack) begin
                            state_q <= CADR;
                            desc_q  <= desc_d;
                            req_q   <= 1'b0;
                        end
                    end
                    CADR: begin
                        if (!desc_q.valid) begin
                            state_q <= ERR;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else if (desc_q.act == ACT_TRAN) begin
                            state_q      <= TFR;
                            xfer_start_q <= 1'b1;
                            xfer_addr_q  <= desc_q.addr;
                            xfer_len_q   <= xfer_len_d;
                        end else begin
                            int_q <= desc_q.irq;
                            if (desc_q.last) begin
                                state_q    <= IDLE;
                                busy_q     <= 1'b0;
                                complete_q <= 1'b1;
                            end else begin
                                state_q     <= FDS;
                                req_q       <= 1'b1;
                                desc_addr_q <= (desc_q.act == ACT_LINK) ? desc_q.addr : next_addr_d;
                            end
                        end
                    end
                    TFR: begin
                        if (xfer_done) begin
                            int_q <= desc_q.irq;
                            if (desc_q.last) begin
                                state_q    <= IDLE;
                                busy_q     <= 1'b0;
                                complete_q <= 1'b1;
                            end else begin
                                state_q     <= FDS;
                                req_q       <= 1'b1;
                                desc_addr_q <= next_addr_d;
                            end
                        end else if (block_done && stop_block_gap_REG) begin
                            state_q <= GAP;
                            pause_q <= 1'b1;
                        end
                    end
                    GAP: begin
                        if (continue_block_gap_REG && !stop_block_gap_REG) begin
                            state_q <= TFR;
                            pause_q <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign desc_rd_req           = req_q;
    assign desc_addr_out         = desc_addr_q;
    assign xfer_start            = xfer_start_q;
    assign xfer_addr             = xfer_addr_q;
    assign xfer_len              = xfer_len_q;
    assign pause_out             = pause_q;
    assign busy                  = busy_q;
    assign transfer_complete_DAT = complete_q;
    assign int_pulse             = int_q;
    assign dma_error             = err_q;

endmodule

// File: doc/adma_seq_ctrl.md
ADMA_SEQ_CTRL -- requirements
Module: adma_seq_ctrl

Interface
REQ-001 SHALL have port clk_in_COM  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_in_COM  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port start_REG  in  1  one-cycle start request from register block.
REQ-004 SHALL have port enable_transfer_mode_REG  in  1  DMA enable; start ignored when 0.
REQ-005 SHALL have port desc_base_REG  in  64  byte address of first descriptor.
REQ-006 SHALL have ports stop_block_gap_REG / continue_block_gap_REG  in  1 each  block-gap stop/continue requests.
REQ-007 SHALL have port error_in_COM  in  1  bus/card error from host.
REQ-008 SHALL have ports desc_rd_req  out  1 / desc_addr_out  out  64  descriptor fetch request and address.
REQ-009 SHALL have ports desc_rd_ack  in  1 / desc_in  in  96  fetch acknowledge and descriptor word: [95:32] data address, [31:16] length, [5:4] act (00 nop, 01 rsv, 10 tran, 11 link), [2] int, [1] end, [0] valid.
REQ-010 SHALL have ports xfer_start  out  1 / xfer_addr  out  64 / xfer_len  out  17  one-cycle transfer launch to data mover.
REQ-011 SHALL have ports block_done / xfer_done  in  1 each  data-mover block-boundary and transfer-finished pulses.
REQ-012 SHALL have ports pause_out, busy, transfer_complete_DAT, int_pulse, dma_error  out  1 each.

Function
REQ-013 SHALL implement states IDLE, FDS (fetch), CADR (decode), TFR (transfer), GAP (block gap), ERR.
REQ-014 IDLE: start_REG=1 and enable_transfer_mode_REG=1 -> load desc_addr_out=desc_base_REG, go FDS; otherwise stay.
REQ-015 FDS: desc_rd_req=1 held until desc_rd_ack; descriptor captured on ack cycle; next state CADR.
REQ-016 CADR (exactly one cycle): valid=0 -> ERR; nop/rsv -> advance; link -> desc_addr_out=desc_in[95:32]; tran -> xfer_start pulse, go TFR.
REQ-017 Advance = desc_addr_out+12 modulo 2^64 (wraps past all-ones), then FDS; if end=1 instead finish.
REQ-018 link with end=1 SHALL finish without following the link.
REQ-019 xfer_len = length field, except length 0 encodes 65536 (17'h10000); xfer_addr = desc_in[95:32], both held stable from xfer_start until xfer_done.
REQ-020 TFR: xfer_done -> advance (or finish if end=1) next cycle; block_done with stop_block_gap_REG=1 -> GAP.
REQ-021 GAP: pause_out=1; continue_block_gap_REG=1 with stop_block_gap_REG=0 -> TFR; stop and continue both 1 -> stay GAP.
REQ-022 xfer_done coincident with block_done+stop SHALL take the xfer_done path (no gap after last block).
REQ-023 Finish: one-cycle transfer_complete_DAT pulse, return IDLE.
REQ-024 int_pulse SHALL pulse one cycle when a descriptor with int=1 completes (tran on xfer_done; nop/link in CADR).
REQ-025 error_in_COM=1 in any non-IDLE state -> ERR next edge, overriding all coincident events.
REQ-026 ERR: dma_error=1 sticky, busy=0, no requests; start_REG with enable=1 clears dma_error and goes FDS from desc_base_REG.
REQ-027 busy=1 in FDS, CADR, TFR, GAP; start_REG while busy ignored.

Reset
REQ-028 reset_in_COM=1 SHALL immediately force IDLE, all outputs 0, desc_addr_out=0, regardless of state (mid-fetch or mid-transfer included).
REQ-029 After reset release, no output SHALL change until an accepted start_REG.

Verification
REQ-030 Base 0x1000, desc tran len 0x0003 end=1 valid=1 -> req addr 0x1000, one xfer_start len 3, xfer_done -> transfer_complete_DAT pulse, busy 0.
REQ-031 Chain nop(0x1000) -> link to 0x2000 (0x100C) -> tran len 0 end int (0x2000) -> fetch addrs 0x1000,0x100C,0x2000; xfer_len 0x10000; int_pulse and complete.
REQ-032 Descriptor valid=0 -> dma_error=1, no xfer_start; later start_REG -> dma_error=0, fetch from base.
REQ-033 block_done with stop_block_gap_REG=1 -> pause_out=1 until continue_block_gap_REG pulse; stop+continue together keeps pause_out=1.
REQ-034 error_in_COM coincident with xfer_done -> ERR, no transfer_complete_DAT; reset_in_COM mid-TFR -> all outputs 0 same cycle.
REQ-035 Base 0xFFFF_FFFF_FFFF_FFF8 nop non-end -> next fetch addr 0x0000_0000_0000_0004.
